// File: rtl/wr_port_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding,
// default data width and a constant clog2 helper.
package wr_port_arbiter_pkg;

    localparam int DSIZE_DEF = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping mod NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic            found_o,
    output logic [IDW-1:0]  idx_o
);

    logic [NREQ-1:0] rotated;
    logic [IDW-1:0]  offset;

    function automatic logic [IDW-1:0] wrapAdd(input logic [IDW-1:0] base, input int step);
        int s;
        s = int'(base) + step;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Rotate so ptr_i lands on bit 0, priority-encode, then map the offset back.
    always_comb begin
        rotated = '0;
        offset  = '0;
        for (int k = 0; k < NREQ; k++) begin
            rotated[k] = req_i[wrapAdd(ptr_i, k)];
        end
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = IDW'(k);
            end
        end
        found_o = |rotated;
        idx_o   = wrapAdd(ptr_i, int'(offset));
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters,
// granting bursts of up to MAXBURST words and honouring the registered wfull.
module wr_port_arbiter
    import wr_port_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int DSIZE    = DSIZE_DEF,
    parameter int MAXBURST = 4,
    parameter int IDW      = 2
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam int BCW = clog2(MAXBURST) + 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAXBURST - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] grantId_q, grantId_d;
    logic [IDW-1:0] rrPtr_q, rrPtr_d;
    logic [BCW-1:0] beatCnt_q, beatCnt_d;
    logic           pickFound;
    logic [IDW-1:0] pickIdx;
    logic           accept;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rrPtr_q),
        .found_o (pickFound),
        .idx_o   (pickIdx)
    );

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q   <= IDLE;
            grantId_q <= '0;
            rrPtr_q   <= '0;
            beatCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grantId_q <= grantId_d;
            rrPtr_q   <= rrPtr_d;
            beatCnt_q <= beatCnt_d;
        end
    end

    // A burst ends on last or the beat limit; both together still end it once.
    always_comb begin
        state_d   = state_q;
        grantId_d = grantId_q;
        rrPtr_d   = rrPtr_q;
        beatCnt_d = beatCnt_q;
        accept    = 1'b0;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        case (state_q)
            IDLE: begin
                if (pickFound) begin
                    grantId_d = pickIdx;
                    beatCnt_d = '0;
                    state_d   = BURST;
                end
            end
            BURST: begin
                req_ready[grantId_q] = ~wfull;
                accept               = req_valid[grantId_q] & ~wfull;
                winc                 = accept;
                wdata                = req_data[int'(grantId_q)*DSIZE +: DSIZE];
                if (accept) begin
                    if (req_last[grantId_q] || (beatCnt_q == LAST_BEAT)) begin
                        state_d = IDLE;
                        rrPtr_d = (grantId_q == LAST_ID) ? '0 : grantId_q + 1'b1;
                    end else begin
                        beatCnt_d = beatCnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q == BURST);
    assign grant_id = grantId_q;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Scoreboard bench for wr_port_arbiter: per-requester word queues drive the
// inputs, expected FIFO writes are queued up front and popped on every winc.
module tb_wr_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DSIZE = 8;

    logic                  wclk;
    logic                  wrst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_last;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  wfull;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [1:0]            grant_id;
    logic                  busy;

    logic [8:0]      reqQ [NREQ][$];
    logic [9:0]      sb [$];
    bit [NREQ-1:0]   popPending;
    bit [NREQ-1:0]   holdMask;

    int vecCount  = 0;
    int errCount  = 0;
    int cycle     = 0;
    int wincCount = 0;
    logic            sWinc;
    logic            sBusy;
    logic [NREQ-1:0] sReady;
    logic [1:0]      sGrant;

    wr_port_arbiter #(
        .NREQ     (NREQ),
        .DSIZE    (DSIZE),
        .MAXBURST (4),
        .IDW      (2)
    ) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int id, input logic [7:0] data, input logic last);
        reqQ[id].push_back({last, data});
    endtask

    task automatic pushExpect(input int id, input logic [7:0] data);
        sb.push_back({2'(id), data});
    endtask

    function automatic bit queuesEmpty();
        bit e;
        e = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (reqQ[i].size() != 0) e = 1'b0;
        end
        return e;
    endfunction

    task automatic updateDrivers();
        logic [8:0] head;
        for (int i = 0; i < NREQ; i++) begin
            if (popPending[i]) begin
                void'(reqQ[i].pop_front());
                popPending[i] = 1'b0;
            end
            if (reqQ[i].size() > 0 && !holdMask[i]) begin
                head                  = reqQ[i][0];
                req_valid[i]          = 1'b1;
                req_last[i]           = head[8];
                req_data[i*DSIZE +: DSIZE] = head[7:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DSIZE +: DSIZE] = '0;
            end
        end
    endtask

    // Sample on the falling edge, then re-drive just after the rising edge.
    task automatic stepCycle();
        logic [9:0] e;
        @(negedge wclk);
        cycle++;
        sWinc  = winc;
        sBusy  = busy;
        sReady = req_ready;
        sGrant = grant_id;
        if (winc) begin
            wincCount++;
            checkOutput("sb_nonempty_on_winc", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("wdata", wdata, e[7:0]);
                checkOutput("grant_id", grant_id, e[9:8]);
                checkOutput("req_ready_onehot", req_ready, 32'(1) << e[9:8]);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i]) popPending[i] = 1'b1;
        end
        @(posedge wclk);
        #1;
        updateDrivers();
    endtask

    task automatic runUntilIdle(input int budget, input bit checkGap);
        int n;
        int prevWinc;
        bit done;
        n = 0;
        prevWinc = -1;
        done = 1'b0;
        while (!done && n < budget) begin
            stepCycle();
            n++;
            if (checkGap && sWinc) begin
                if (prevWinc >= 0) checkOutput("rr_gap", cycle - prevWinc, 2);
                prevWinc = cycle;
            end
            done = queuesEmpty() && (sb.size() == 0) && !sBusy;
        end
        checkOutput("drain_done", 32'(done), 1);
    endtask

    task automatic waitWincs(input int count, input int budget);
        int start;
        int n;
        start = wincCount;
        n = 0;
        while (wincCount < start + count && n < budget) begin
            stepCycle();
            n++;
        end
        checkOutput("wait_beats", wincCount - start, count);
    endtask

    task automatic applyReset();
        wrst_n = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    initial begin
        int start;
        logic [4:0] pat;
        wrst_n     = 1'b0;
        wfull      = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_data   = '0;
        popPending = '0;
        holdMask   = '0;
        #7;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_winc", winc, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_grant_id", grant_id, 0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;

        $display("[TB] single requester packet");
        applyStimulus(0, 8'hA1, 1'b0);
        applyStimulus(0, 8'hA2, 1'b0);
        applyStimulus(0, 8'hA3, 1'b1);
        pushExpect(0, 8'hA1);
        pushExpect(0, 8'hA2);
        pushExpect(0, 8'hA3);
        updateDrivers();
        pat = 5'b01110;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput("t1_busy", sBusy, pat[c]);
            checkOutput("t1_winc", sWinc, pat[c]);
        end
        checkOutput("t1_sb_empty", sb.size(), 0);

        // Pointer now sits at 1, so requester 1 wins over requester 0.
        applyStimulus(0, 8'h10, 1'b1);
        applyStimulus(1, 8'h11, 1'b1);
        pushExpect(1, 8'h11);
        pushExpect(0, 8'h10);
        updateDrivers();
        runUntilIdle(30, 1'b0);

        $display("[TB] round-robin rotation");
        applyReset();
        for (int i = 0; i < NREQ; i++) begin
            applyStimulus(i, 8'(8'h20 + i), 1'b1);
            applyStimulus(i, 8'(8'h30 + i), 1'b1);
        end
        for (int i = 0; i < NREQ; i++) pushExpect(i, 8'(8'h20 + i));
        for (int i = 0; i < NREQ; i++) pushExpect(i, 8'(8'h30 + i));
        updateDrivers();
        runUntilIdle(60, 1'b1);

        $display("[TB] burst length cut");
        applyReset();
        for (int w = 0; w < 6; w++) applyStimulus(2, 8'(8'h40 + w), 1'(w == 5));
        applyStimulus(3, 8'h50, 1'b1);
        for (int w = 0; w < 4; w++) pushExpect(2, 8'(8'h40 + w));
        pushExpect(3, 8'h50);
        pushExpect(2, 8'h44);
        pushExpect(2, 8'h45);
        updateDrivers();
        runUntilIdle(60, 1'b0);

        $display("[TB] backpressure");
        start = wincCount;
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1, 8'(8'h60 + w), 1'(w == 3));
            pushExpect(1, 8'(8'h60 + w));
        end
        updateDrivers();
        waitWincs(2, 10);
        wfull = 1'b1;
        for (int c = 0; c < 5; c++) begin
            stepCycle();
            checkOutput("bp_winc", sWinc, 0);
            checkOutput("bp_ready", sReady, 0);
            checkOutput("bp_busy", sBusy, 1);
        end
        wfull = 1'b0;
        stepCycle();
        checkOutput("bp_resume", sWinc, 1);
        runUntilIdle(30, 1'b0);
        checkOutput("bp_total_words", wincCount - start, 4);

        $display("[TB] valid bubble");
        for (int w = 0; w < 4; w++) begin
            applyStimulus(2, 8'(8'h70 + w), 1'(w == 3));
            pushExpect(2, 8'(8'h70 + w));
        end
        applyStimulus(0, 8'h80, 1'b1);
        applyStimulus(3, 8'h90, 1'b1);
        pushExpect(3, 8'h90);
        pushExpect(0, 8'h80);
        updateDrivers();
        waitWincs(2, 10);
        holdMask[2] = 1'b1;
        updateDrivers();
        for (int c = 0; c < 3; c++) begin
            stepCycle();
            checkOutput("bub_winc", sWinc, 0);
            checkOutput("bub_other_ready", sReady & 4'b1011, 0);
            checkOutput("bub_busy", sBusy, 1);
            checkOutput("bub_grant", sGrant, 2);
        end
        holdMask[2] = 1'b0;
        updateDrivers();
        runUntilIdle(40, 1'b0);

        $display("[TB] reset mid-burst");
        for (int w = 0; w < 4; w++) applyStimulus(3, 8'(8'hB0 + w), 1'(w == 3));
        pushExpect(3, 8'hB0);
        pushExpect(3, 8'hB1);
        updateDrivers();
        waitWincs(2, 10);
        #2;
        wrst_n = 1'b0;
        #1;
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_winc", winc, 0);
        checkOutput("rstmid_ready", req_ready, 0);
        applyStimulus(0, 8'hC0, 1'b1);
        pushExpect(0, 8'hC0);
        pushExpect(3, 8'hB2);
        pushExpect(3, 8'hB3);
        repeat (2) stepCycle();
        wrst_n = 1'b1;
        updateDrivers();
        runUntilIdle(40, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
